sci_slave: RTL
==============

SCI_SLAVE -- requirements
Module: sci_slave

Interface
- REQ-001: Parameter ADDR_WIDTH, default 4, serial address length in bits (1..32).
- REQ-002: Parameter DATA_WIDTH, default 8, serial data length in bits (1..32).
- REQ-003: clk  input  1  single clock; all logic samples on the rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: csn  input  1  this peripheral's chip select, active low.
- REQ-006: req  input  1  serial request line from master.
- REQ-007: resp  output  1  serial read data; 1'bz whenever not driven.
- REQ-008: ack  output  1  acknowledge; 1'bz whenever not driven.
- REQ-009: wreq  output  1  one-cycle write strobe to the register file.
- REQ-010: waddr  output  ADDR_WIDTH  write address, valid with wreq.
- REQ-011: wdata  output  DATA_WIDTH  write data, valid with wreq.
- REQ-012: rreq  output  1  one-cycle read strobe to the register file.
- REQ-013: raddr  output  ADDR_WIDTH  read address, valid with rreq and held until rvalid.
- REQ-014: rdata  input  DATA_WIDTH  read data, sampled when rvalid=1.
- REQ-015: rvalid  input  1  read data valid; may be high in the rreq cycle or any later cycle.

Function
- REQ-016: States SHALL be IDLE, ADDR, WDATA, WACK, RWAIT, RDATA, RHOLD.
- REQ-017: IDLE: on the first edge with csn=0, req SHALL be sampled as write-not-read (1=write); the next state SHALL be ADDR.
- REQ-018: ADDR: ADDR_WIDTH consecutive edges SHALL shift req into the address, LSB first; then state WDATA on write, RWAIT on read.
- REQ-019: WDATA: DATA_WIDTH consecutive edges SHALL shift req into the data, LSB first.
- REQ-020: On the edge sampling the last data bit, the block SHALL go to WACK, register waddr/wdata, pulse wreq high for exactly one cycle, and drive ack=1.
- REQ-021: WACK: ack SHALL be held at 1 and resp SHALL be 1'bz until csn=1 is sampled; then the state SHALL be IDLE.
- REQ-022: RWAIT: rreq SHALL pulse for one cycle in the cycle after the last address bit is sampled; on the first edge sampling rvalid=1, rdata SHALL be captured, ack=1 and resp=rdata[0] driven, and state RDATA entered.
- REQ-023: RDATA: each following edge SHALL shift resp to the next bit (LSB first) with ack=1; after DATA_WIDTH bits have been presented, state RHOLD.
- REQ-024: RHOLD: ack=1, resp=0 SHALL be driven until csn=1, then IDLE.
- REQ-025: In IDLE, ADDR, WDATA and RWAIT, ack and resp SHALL be 1'bz.
- REQ-026: csn=1 sampled in ADDR, WDATA, RWAIT or RDATA SHALL abort: state IDLE, no wreq, and rreq suppressed if not yet issued.
- REQ-027: An rvalid arriving after an abort SHALL be ignored.
- REQ-028: Bit counters SHALL be sized $clog2(max(ADDR_WIDTH,DATA_WIDTH))+1 and cleared on every state entry.

Reset
- REQ-029: With rst=1 at an edge, the state SHALL be IDLE, counters and shift registers 0, and wreq=0, rreq=0, waddr=0, wdata=0, raddr=0.
- REQ-030: After rst, ack and resp SHALL be 1'bz.
- REQ-031: rst mid-transaction SHALL abort without a wreq pulse; a new transaction SHALL only start on a csn falling edge after rst is released.

Configuration
- REQ-032: With macro SCI_SLAVE_ABORT_CNT_EN defined, output abort_cnt [7:0] SHALL exist: it counts REQ-026 aborts, saturates at 255, and is reset to 0.
- REQ-033: Without SCI_SLAVE_ABORT_CNT_EN, the abort_cnt port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
- REQ-034: sci_pkg SHALL hold the state enum typedef sci_slave_state_t and the constants SCI_WRITE=1'b1 and SCI_READ=1'b0.
- REQ-035: One sub-module, sci_slave_shifter (parameterised LSB-first shift register with load, shift-in and shift-out), SHALL be used for address, write data and read data.

Verification
- REQ-036: Bench SHALL drive the master with ADDR_WIDTH=4, DATA_WIDTH=8 and cover the following.
- REQ-037: Write addr=0x5, data=0xA3 -> exactly one wreq with waddr=0x5, wdata=0xA3; ack=1 until csn rises, then ack=1'bz.
- REQ-038: Read addr=0x9 with rvalid in the rreq cycle and rdata=0x3C -> one rreq with raddr=0x9; master reads 0x3C; ack=1 on all 8 beats.
- REQ-039: Read with rvalid delayed 5 cycles, rdata=0xFF -> ack=1'bz for those 5 cycles, then 0xFF is read correctly.
- REQ-040: csn raised after 2 data bits of a write -> no wreq, ack stays 1'bz, abort_cnt=1 (macro on); the next write 0x1/0x55 completes correctly.
- REQ-041: rst asserted during RDATA -> ack/resp become 1'bz on the next edge; a following read of addr 0x2 returns the correct rdata.

Source files
------------

// File: rtl/sci_pkg.sv
// Shared definitions for the SCI slave.
// Holds the FSM state type and the encoding of the direction bit that the
// master sends first in every transaction.
package sci_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WACK  = 3'd3,
    RWAIT = 3'd4,
    RDATA = 3'd5,
    RHOLD = 3'd6
  } sci_slave_state_t;

  localparam logic SCI_WRITE = 1'b1;
  localparam logic SCI_READ  = 1'b0;

endpackage

// File: rtl/sci_slave_shifter.sv
// LSB-first shift register used for the serial address, write data and
// read data paths of the SCI slave.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears the register
//   clr       synchronous clear (lower priority than rst)
//   load      parallel load of load_val
//   load_val  parallel value to load
//   shift     shift shift_in into the MSB, everything moves toward bit 0
//   shift_in  serial input bit
//   q         current register contents; q[0] is the serial output bit
//   shifted   value q would take on a shift this cycle
module sci_slave_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             shift_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] shifted
);

  // After WIDTH shifts the first bit received sits in bit 0, which gives
  // LSB-first ordering for both shift-in and shift-out.
  generate
    if (WIDTH == 1) begin : g_one
      assign shifted = shift_in;
    end else begin : g_many
      assign shifted = {shift_in, q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/sci_slave.sv
// SCI slave: serial-to-register-file bridge.
// A transaction starts on csn going low: the first req bit selects write (1)
// or read (0), then ADDR_WIDTH address bits follow LSB first. Writes carry
// DATA_WIDTH data bits and produce a one-cycle wreq. Reads issue a one-cycle
// rreq, wait for rvalid and return the data LSB first on resp. ack/resp are
// tri-stated whenever the slave is not driving them.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   csn                 chip select, active low
//   req                 serial line from master
//   resp, ack           tri-state serial read data and acknowledge
//   wreq, waddr, wdata  register-file write strobe / address / data
//   rreq, raddr         register-file read strobe / address
//   rdata, rvalid       register-file read data / valid
//   abort_cnt           saturating abort counter (only with
//                       SCI_SLAVE_ABORT_CNT_EN defined)
// Build option: define SCI_SLAVE_ABORT_CNT_EN to add abort_cnt.
module sci_slave
  import sci_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csn,
  input  logic                  req,
  output wire                   resp,
  output wire                   ack,
  output logic                  wreq,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  rreq,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rvalid
`ifdef SCI_SLAVE_ABORT_CNT_EN
  ,
  output logic [7:0]            abort_cnt
`endif
);

  localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAXW) + 1;
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_WIDTH - 1);

  sci_slave_state_t state;
  logic [CNT_W-1:0] cnt;
  logic             is_write;
  logic             armed;
  logic             ack_en;
  logic             resp_en;

  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic [DATA_WIDTH-1:0] wd_q, wd_next;
  logic [DATA_WIDTH-1:0] rd_q, rd_next;
  logic                  unused_bits;

  assign unused_bits = ^{wd_q, rd_q, rd_next};

  sci_slave_shifter #(.WIDTH(ADDR_WIDTH)) u_addr (
    .clk(clk), .rst(rst), .clr(state == IDLE),
    .load(1'b0), .load_val('0),
    .shift(state == ADDR && !csn), .shift_in(req),
    .q(addr_q), .shifted(addr_next)
  );

  sci_slave_shifter #(.WIDTH(DATA_WIDTH)) u_wdata (
    .clk(clk), .rst(rst), .clr(state == IDLE),
    .load(1'b0), .load_val('0),
    .shift(state == WDATA && !csn), .shift_in(req),
    .q(wd_q), .shifted(wd_next)
  );

  // Read data is loaded on the rvalid edge and shifted once per presented
  // bit; bit 0 of the register is always the bit on resp.
  sci_slave_shifter #(.WIDTH(DATA_WIDTH)) u_rdata (
    .clk(clk), .rst(rst), .clr(state == IDLE),
    .load(state == RWAIT && !csn && rvalid), .load_val(rdata),
    .shift(state == RDATA && !csn && cnt != D_LAST), .shift_in(1'b0),
    .q(rd_q), .shifted(rd_next)
  );

  assign ack  = ack_en  ? 1'b1 : 1'bz;
  assign resp = resp_en ? ((state == RDATA) ? rd_q[0] : 1'b0) : 1'bz;

  // Main FSM. armed blocks a start while csn is still low coming out of
  // reset, so a new transaction needs a fresh falling edge of csn.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_write <= 1'b0;
      armed    <= 1'b0;
      ack_en   <= 1'b0;
      resp_en  <= 1'b0;
      wreq     <= 1'b0;
      rreq     <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      raddr    <= '0;
    end else begin
      wreq <= 1'b0;
      rreq <= 1'b0;
      if (csn) armed <= 1'b1;
      case (state)
        IDLE: begin
          ack_en  <= 1'b0;
          resp_en <= 1'b0;
          if (!csn && armed) begin
            is_write <= req;
            cnt      <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (csn) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == A_LAST) begin
            cnt <= '0;
            if (is_write == SCI_WRITE) begin
              state <= WDATA;
            end else begin
              state <= RWAIT;
              rreq  <= 1'b1;
              raddr <= addr_next;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WDATA: begin
          if (csn) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == D_LAST) begin
            cnt    <= '0;
            state  <= WACK;
            wreq   <= 1'b1;
            waddr  <= addr_q;
            wdata  <= wd_next;
            ack_en <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WACK: begin
          if (csn) begin
            state  <= IDLE;
            ack_en <= 1'b0;
          end
        end
        RWAIT: begin
          if (csn) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (rvalid) begin
            state   <= RDATA;
            cnt     <= '0;
            ack_en  <= 1'b1;
            resp_en <= 1'b1;
          end
        end
        RDATA: begin
          if (csn) begin
            state   <= IDLE;
            cnt     <= '0;
            ack_en  <= 1'b0;
            resp_en <= 1'b0;
          end else if (cnt == D_LAST) begin
            state <= RHOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RHOLD: begin
          if (csn) begin
            state   <= IDLE;
            ack_en  <= 1'b0;
            resp_en <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCI_SLAVE_ABORT_CNT_EN
  // Counts csn aborts from the mid-transaction states, saturating at 255.
  logic abort_now;
  assign abort_now = csn && (state == ADDR || state == WDATA ||
                             state == RWAIT || state == RDATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      abort_cnt <= 8'd0;
    end else if (abort_now && abort_cnt != 8'hFF) begin
      abort_cnt <= abort_cnt + 8'd1;
    end
  end
`endif

endmodule
